i2c_write_arbiter: RTL and testbench

Round-robin scheduler that shares one byte-level I2C write engine between two configuration requesters (HDMI transmitter init and a second peripheral's init sequencer). Each requester presents a complete 24-bit write {slave address, register, value}; the block grants the engine, issues the transaction, retries on NACK, enforces a bus-free gap between transactions, and returns a done/error pulse to the owning requester. It sits between the config sequencers and the I2C engine in the CLK_I2C domain.

---
 rtl/i2c_write_arbiter.sv | 167 ++++++++++++++++
 tb/tb_i2c_write_arbiter.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_write_arbiter.sv
// i2c_write_arbiter
// Round-robin arbiter that shares one byte-level I2C write engine between two
// configuration requesters. It issues each 24-bit write, retries on NACK,
// aborts on timeout, inserts a bus-free gap after every engine transaction
// and returns a done/err pulse to the requester that owned the transaction.
module i2c_write_arbiter #(
    parameter int unsigned GAP_CYCLES     = 4,
    parameter int unsigned MAX_RETRY      = 3,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic        CLK_I2C,
    input  logic        RST,
    input  logic        req0,
    input  logic        req1,
    input  logic [23:0] data0,
    input  logic [23:0] data1,
    output logic        done0,
    output logic        done1,
    output logic        err0,
    output logic        err1,
    output logic        eng_start,
    output logic [23:0] eng_data,
    input  logic        eng_done,
    input  logic        eng_nack,
    output logic        eng_abort,
    output logic        owner,
    output logic        busy
);

    localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned GW = $clog2(GAP_CYCLES + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND,
        GAP
    } state_t;

    state_t          state;
    logic            last_owner;
    logic            gap_to_issue;
    logic [RW-1:0]   retry_cnt;
    logic [TW-1:0]   timeout_cnt;
    logic [GW-1:0]   gap_cnt;
    logic            grant;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = ~last_owner;
        end else begin
            grant = req1;
        end
    end

    // Scheduler FSM with all outputs registered
    always_ff @(posedge CLK_I2C) begin
        if (RST) begin
            state        <= IDLE;
            last_owner   <= 1'b1;
            gap_to_issue <= 1'b0;
            retry_cnt    <= '0;
            timeout_cnt  <= '0;
            gap_cnt      <= '0;
            done0        <= 1'b0;
            done1        <= 1'b0;
            err0         <= 1'b0;
            err1         <= 1'b0;
            eng_start    <= 1'b0;
            eng_abort    <= 1'b0;
            eng_data     <= '0;
            owner        <= 1'b0;
            busy         <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            eng_abort <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            err0      <= 1'b0;
            err1      <= 1'b0;

            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= grant;
                        eng_data  <= grant ? data1 : data0;
                        retry_cnt <= '0;
                        eng_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    timeout_cnt <= '0;
                    state       <= WAIT;
                end

                WAIT: begin
                    if (eng_done) begin
                        if (!eng_nack) begin
                            done0 <= ~owner;
                            done1 <= owner;
                            state <= RESPOND;
                        end else if (retry_cnt < RW'(MAX_RETRY)) begin
                            retry_cnt    <= retry_cnt + RW'(1);
                            gap_cnt      <= '0;
                            gap_to_issue <= 1'b1;
                            state        <= GAP;
                        end else begin
                            done0 <= ~owner;
                            done1 <= owner;
                            err0  <= ~owner;
                            err1  <= owner;
                            state <= RESPOND;
                        end
                    end else if (timeout_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        eng_abort <= 1'b1;
                        state     <= RESPOND;
                    end else begin
                        timeout_cnt <= timeout_cnt + TW'(1);
                    end
                end

                // A timeout enters with eng_abort high and no done yet, so it
                // spends one extra cycle here to emit done/err after the abort.
                RESPOND: begin
                    if (eng_abort) begin
                        done0 <= ~owner;
                        done1 <= owner;
                        err0  <= ~owner;
                        err1  <= owner;
                    end else begin
                        last_owner   <= owner;
                        gap_cnt      <= '0;
                        gap_to_issue <= 1'b0;
                        state        <= GAP;
                    end
                end

                GAP: begin
                    if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
                        if (gap_to_issue) begin
                            eng_start <= 1'b1;
                            state     <= ISSUE;
                        end else begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end else begin
                        gap_cnt <= gap_cnt + GW'(1);
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_write_arbiter.sv
// Testbench for i2c_write_arbiter: behavioural engine model, scoreboard of
// expected transactions (data at eng_start, owner/err at done) and one task
// per scenario.
module tb_i2c_write_arbiter;

    localparam int unsigned G  = 4;
    localparam int unsigned MR = 3;
    localparam int unsigned TO = 64;

    logic        CLK_I2C;
    logic        RST;
    logic        req0, req1;
    logic [23:0] data0, data1;
    logic        done0, done1, err0, err1;
    logic        eng_start;
    logic [23:0] eng_data;
    logic        eng_done, eng_nack;
    logic        eng_abort;
    logic        owner;
    logic        busy;

    typedef struct {
        bit          owner;
        bit          err;
        logic [23:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   n_done = 0;
    int   n_abort = 0;
    int   abort_cyc = 0;
    int   start_cyc[$];
    int   done_cyc[$];

    int   eng_lat = 20;
    int   nack_left = 0;
    bit   eng_hang = 0;

    exp_t        mon_e;
    logic [3:0]  mon_exp;

    i2c_write_arbiter #(
        .GAP_CYCLES    (G),
        .MAX_RETRY     (MR),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK_I2C  (CLK_I2C),
        .RST      (RST),
        .req0     (req0),
        .req1     (req1),
        .data0    (data0),
        .data1    (data1),
        .done0    (done0),
        .done1    (done1),
        .err0     (err0),
        .err1     (err1),
        .eng_start(eng_start),
        .eng_data (eng_data),
        .eng_done (eng_done),
        .eng_nack (eng_nack),
        .eng_abort(eng_abort),
        .owner    (owner),
        .busy     (busy)
    );

    initial begin
        CLK_I2C = 1'b0;
        forever #5 CLK_I2C = ~CLK_I2C;
    end

    initial forever begin
        @(posedge CLK_I2C);
        cyc++;
    end

    // Engine model: answers eng_start after eng_lat cycles, NACKing while nack_left > 0
    initial begin
        eng_done = 1'b0;
        eng_nack = 1'b0;
        forever begin
            @(negedge CLK_I2C);
            if (eng_start && !eng_hang) begin
                repeat (eng_lat - 1) @(negedge CLK_I2C);
                eng_done = 1'b1;
                eng_nack = (nack_left > 0);
                if (nack_left > 0) nack_left--;
                @(negedge CLK_I2C);
                eng_done = 1'b0;
                eng_nack = 1'b0;
            end
        end
    end

    // Scoreboard monitor: data checked at every eng_start, owner/err popped at done
    initial forever begin
        @(negedge CLK_I2C);
        if (eng_start) begin
            n_start++;
            start_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL eng_start_unexpected got data=%h required no start", eng_data);
            end else if (eng_data !== exp_q[0].data) begin
                errors++;
                $display("FAIL eng_data got %h required %h", eng_data, exp_q[0].data);
            end
        end
        if (done0 || done1) begin
            n_done++;
            done_cyc.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL done_unexpected got {d1,e1,d0,e0}=%b required none", {done1, err1, done0, err0});
            end else begin
                mon_e   = exp_q.pop_front();
                mon_exp = mon_e.owner ? {1'b1, mon_e.err, 2'b00} : {2'b00, 1'b1, mon_e.err};
                if ({done1, err1, done0, err0} !== mon_exp) begin
                    errors++;
                    $display("FAIL done_result got {d1,e1,d0,e0}=%b required %b", {done1, err1, done0, err0}, mon_exp);
                end
            end
        end else if (err0 || err1) begin
            checks++;
            errors++;
            $display("FAIL err_without_done got err0=%b err1=%b required 0", err0, err1);
        end
        if (eng_abort) begin
            n_abort++;
            abort_cyc = cyc;
        end
    end

    task automatic wait_done(input int bound, output bit ok);
        int n0;
        n0 = n_done;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK_I2C);
            #1;
            if (n_done != n0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_start(input int bound, output bit ok);
        int n0;
        n0 = n_start;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK_I2C);
            #1;
            if (n_start != n0) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge CLK_I2C);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle_cycles(2);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        RST = 1'b1;
        idle_cycles(3);
        checks++;
        if ({done0, done1, err0, err1, eng_start, eng_abort, eng_data, owner, busy} !== 32'h0) begin
            errors++;
            $display("FAIL reset_values got %h required 0",
                     {done0, done1, err0, err1, eng_start, eng_abort, eng_data, owner, busy});
        end
        RST = 1'b0;
        idle_cycles(2);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_busy got %b required 0", busy);
        end
    endtask

    task automatic test_single();
        int s0, c;
        bit ok;
        s0 = n_start; eng_lat = 20; nack_left = 0;
        data0 = 24'h724110;
        exp_q.push_back('{1'b0, 1'b0, 24'h724110});
        c = cyc;
        req0 = 1'b1;
        wait_done(200, ok);
        req0 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL single_done_timeout got no done required done0");
            return;
        end
        checks++;
        if (start_cyc[$] != c + 1) begin
            errors++;
            $display("FAIL single_start_latency got %0d required %0d", start_cyc[$] - c, 1);
        end
        checks++;
        if (done_cyc[$] - start_cyc[$] != 20) begin
            errors++;
            $display("FAIL single_done_latency got %0d required 20", done_cyc[$] - start_cyc[$]);
        end
        checks++;
        if (n_start - s0 != 1) begin
            errors++;
            $display("FAIL single_start_count got %0d required 1", n_start - s0);
        end
        idle_cycles(G);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL single_busy_in_gap got %b required 1", busy);
        end
        idle_cycles(1);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL single_busy_after_gap got %b required 0", busy);
        end
    endtask

    task automatic test_round_robin();
        int si, di, need0, need1;
        bit ok;
        do_reset();
        eng_lat = 6; nack_left = 0;
        data0 = 24'hA00111;
        data1 = 24'hB00222;
        exp_q.push_back('{1'b0, 1'b0, 24'hA00111});
        exp_q.push_back('{1'b1, 1'b0, 24'hB00222});
        exp_q.push_back('{1'b0, 1'b0, 24'hA00111});
        exp_q.push_back('{1'b1, 1'b0, 24'hB00222});
        si = start_cyc.size(); di = done_cyc.size();
        need0 = 2; need1 = 2;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_done(300, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL rr_done_timeout got no done required transaction %0d", k);
                req0 = 1'b0; req1 = 1'b0;
                return;
            end
            if (done0) begin req0 = 1'b0; need0--; end
            else       begin req1 = 1'b0; need1--; end
            idle_cycles(1);
            if (need0 > 0) req0 = 1'b1;
            if (need1 > 0) req1 = 1'b1;
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (start_cyc[si + k + 1] - done_cyc[di + k] != G + 2) begin
                errors++;
                $display("FAIL rr_spacing got %0d required %0d", start_cyc[si + k + 1] - done_cyc[di + k], G + 2);
            end
        end
        idle_cycles(G + 2);
    endtask

    task automatic test_nack_all();
        int s0, si;
        bit ok;
        eng_lat = 8; nack_left = 100;
        data0 = 24'h5AC30F;
        exp_q.push_back('{1'b0, 1'b1, 24'h5AC30F});
        s0 = n_start; si = start_cyc.size();
        req0 = 1'b1;
        wait_start(20, ok);
        data0 = 24'hFFFFFF;
        wait_done(500, ok);
        req0 = 1'b0;
        nack_left = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL nack_all_timeout got no done required done0");
            return;
        end
        checks++;
        if (n_start - s0 != MR + 1) begin
            errors++;
            $display("FAIL nack_all_starts got %0d required %0d", n_start - s0, MR + 1);
        end
        checks++;
        if (start_cyc[si + 1] - start_cyc[si] != 8 + G) begin
            errors++;
            $display("FAIL nack_retry_spacing got %0d required %0d", start_cyc[si + 1] - start_cyc[si], 8 + G);
        end
        idle_cycles(G + 2);
    endtask

    task automatic test_nack_twice();
        int s0;
        bit ok;
        eng_lat = 5; nack_left = 2;
        data1 = 24'h3C10AB;
        exp_q.push_back('{1'b1, 1'b0, 24'h3C10AB});
        s0 = n_start;
        req1 = 1'b1;
        wait_done(500, ok);
        req1 = 1'b0;
        checks++;
        if (!ok || n_start - s0 != 3) begin
            errors++;
            $display("FAIL nack_twice_starts got %0d required 3", n_start - s0);
        end
        idle_cycles(G + 2);
    endtask

    task automatic test_timeout();
        int s0, a0;
        bit ok;
        eng_hang = 1'b1;
        data0 = 24'h200F01;
        exp_q.push_back('{1'b0, 1'b1, 24'h200F01});
        s0 = n_start; a0 = n_abort;
        req0 = 1'b1;
        wait_done(300, ok);
        req0 = 1'b0;
        eng_hang = 1'b0;
        checks++;
        if (!ok || n_abort - a0 != 1) begin
            errors++;
            $display("FAIL timeout_abort_count got %0d required 1", n_abort - a0);
        end
        checks++;
        if (abort_cyc - start_cyc[$] != TO + 1) begin
            errors++;
            $display("FAIL timeout_abort_time got %0d required %0d", abort_cyc - start_cyc[$], TO + 1);
        end
        checks++;
        if (done_cyc[$] - abort_cyc != 1) begin
            errors++;
            $display("FAIL timeout_done_after_abort got %0d required 1", done_cyc[$] - abort_cyc);
        end
        checks++;
        if (n_start - s0 != 1) begin
            errors++;
            $display("FAIL timeout_no_retry got %0d required 1", n_start - s0);
        end
        idle_cycles(G + 2);
        // engine completion lands on the last WAIT cycle before timeout
        eng_lat = TO + 1;
        data0 = 24'h200F02;
        exp_q.push_back('{1'b0, 1'b0, 24'h200F02});
        a0 = n_abort;
        req0 = 1'b1;
        wait_done(300, ok);
        req0 = 1'b0;
        checks++;
        if (!ok || n_abort != a0) begin
            errors++;
            $display("FAIL coincident_abort got %0d required 0", n_abort - a0);
        end
        checks++;
        if (done_cyc[$] - start_cyc[$] != TO + 1) begin
            errors++;
            $display("FAIL coincident_done_time got %0d required %0d", done_cyc[$] - start_cyc[$], TO + 1);
        end
        idle_cycles(G + 2);
    endtask

    task automatic test_reset_mid();
        int d0, a0;
        bit ok;
        eng_hang = 1'b1;
        data1 = 24'h445566;
        exp_q.push_back('{1'b1, 1'b0, 24'h445566});
        req1 = 1'b1;
        wait_start(20, ok);
        idle_cycles(5);
        data0 = 24'h112233;
        req0 = 1'b1;
        d0 = n_done; a0 = n_abort;
        RST = 1'b1;
        idle_cycles(1);
        checks++;
        if ({done0, done1, err0, err1, eng_start, eng_abort, eng_data, owner, busy} !== 32'h0) begin
            errors++;
            $display("FAIL midreset_values got %h required 0",
                     {done0, done1, err0, err1, eng_start, eng_abort, eng_data, owner, busy});
        end
        checks++;
        if (n_done != d0 || n_abort != a0) begin
            errors++;
            $display("FAIL midreset_pulses got done=%0d abort=%0d required 0 0", n_done - d0, n_abort - a0);
        end
        exp_q.delete();
        exp_q.push_back('{1'b0, 1'b0, 24'h112233});
        exp_q.push_back('{1'b1, 1'b0, 24'h445566});
        eng_hang = 1'b0;
        eng_lat = 10;
        RST = 1'b0;
        wait_done(200, ok);
        checks++;
        if (!ok || done0 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_priority got done0=%b required 1", done0);
        end
        req0 = 1'b0;
        wait_done(200, ok);
        req1 = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL midreset_second_timeout got no done required done1");
        end
        idle_cycles(G + 2);
    endtask

    initial begin
        RST = 1'b1; req0 = 1'b0; req1 = 1'b0; data0 = '0; data1 = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_nack_all();
        test_nack_twice();
        test_timeout();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
